// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and helpers for the time-shared FIR filter
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam int SAT_W = 128;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Clamp a sign-extended value to the signed range of a data_w-bit word
    function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] acc,
                                                          input int data_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (data_w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - signed multiply with registered accumulator, clear and enable
module fir_mac #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_sum
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    assign prod    = PROD_W'(a) * PROD_W'(b);
    // Running sum including this cycle's product, so the last tap is visible before it is registered
    assign acc_sum = acc + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/fir_filter_tdm.sv
// rtl/fir_filter_tdm.sv - TAPS-long FIR on one shared MAC; FIR_TDM_SAT_EN selects output saturation
module fir_filter_tdm
    import fir_pkg::*;
#(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int TAPS      = 16,
    parameter int OUT_SHIFT = 17,
    parameter int ACC_W     = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   input_sig,
    input  logic                       ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       ovr_clr,
    output logic signed [DATA_W-1:0]   filtred_sig,
    output logic                       valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    fir_state_t state_q, state_d;

    logic signed [DATA_W-1:0] dline [TAPS];
    logic signed [COEF_W-1:0] coef  [TAPS];
    logic [AW-1:0] wp, rd_idx, k;
    logic [AW-1:0] wp_nxt, rd_dec;
    logic sample_acc, sample_drop, coef_ok;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [DATA_W-1:0] filt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ready ? MAC : IDLE;
            MAC:     state_d = (k == LAST) ? OUT : MAC;
            OUT:     state_d = ready ? MAC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        valid       = 1'b0;
        sample_acc  = 1'b0;
        sample_drop = 1'b0;
        case (state_q)
            IDLE: sample_acc = ready;
            MAC: begin
                busy        = 1'b1;
                sample_drop = ready;
            end
            OUT: begin
                valid      = 1'b1;
                sample_acc = ready;
            end
            default: ;
        endcase
    end

    assign wp_nxt  = (wp == LAST) ? '0 : wp + AW'(1);
    assign rd_dec  = (rd_idx == '0) ? LAST : rd_idx - AW'(1);
    assign coef_ok = ({1'b0, coef_addr} < (AW + 1)'(TAPS));

    // The MAC walks backwards from the newest sample while k walks forwards through h
    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sample_acc),
        .en      (busy),
        .a       (dline[rd_idx]),
        .b       (coef[k]),
        .acc_sum (acc_nxt)
    );

`ifdef FIR_TDM_SAT_EN
    logic signed [ACC_W-1:0] acc_sh;
    assign acc_sh   = acc_nxt >>> OUT_SHIFT;
    assign filt_nxt = DATA_W'(sat_trunc(SAT_W'(acc_sh), DATA_W));
`else
    assign filt_nxt = DATA_W'(acc_nxt >>> OUT_SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
            wp          <= '0;
            rd_idx      <= '0;
            k           <= '0;
            filtred_sig <= '0;
            overrun     <= 1'b0;
        end else begin
            if (sample_acc) begin
                dline[wp] <= input_sig;
                wp        <= wp_nxt;
                rd_idx    <= wp;
                k         <= '0;
            end else if (busy) begin
                k      <= k + AW'(1);
                rd_idx <= rd_dec;
            end
            if (coef_we && !busy && coef_ok) begin
                coef[coef_addr] <= coef_data;
            end
            if (busy && k == LAST) begin
                filtred_sig <= filt_nxt;
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (sample_drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_tdm.sv
// tb/tb_fir_filter_tdm.sv - scoreboard bench for fir_filter_tdm with TAPS=4, OUT_SHIFT=0
module tb_fir_filter_tdm;

    localparam int DW   = 18;
    localparam int CW   = 18;
    localparam int TAPS = 4;
    localparam int FS   = 131071;

`ifdef FIR_TDM_SAT_EN
    localparam logic signed [DW-1:0] FS1 = 18'sd131071;
    localparam logic signed [DW-1:0] FS2 = 18'sd131071;
    localparam logic signed [DW-1:0] FS3 = 18'sd131071;
    localparam logic signed [DW-1:0] FS4 = 18'sd131071;
`else
    localparam logic signed [DW-1:0] FS1 = 18'sd1;
    localparam logic signed [DW-1:0] FS2 = 18'sd2;
    localparam logic signed [DW-1:0] FS3 = 18'sd3;
    localparam logic signed [DW-1:0] FS4 = 18'sd4;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] input_sig;
    logic                 ready;
    logic                 coef_we;
    logic [1:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 ovr_clr;
    logic signed [DW-1:0] filtred_sig;
    logic                 valid;
    logic                 busy;
    logic                 overrun;

    typedef struct {
        logic signed [DW-1:0] val;
        int                   due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_filter_tdm #(
        .DATA_W    (DW),
        .COEF_W    (CW),
        .TAPS      (TAPS),
        .OUT_SHIFT (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_sig   (input_sig),
        .ready       (ready),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .ovr_clr     (ovr_clr),
        .filtred_sig (filtred_sig),
        .valid       (valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input logic [1:0] a, input logic signed [CW-1:0] d);
        coef_addr = a;
        coef_data = d;
        coef_we   = 1'b1;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic send(input logic signed [DW-1:0] x, input logic signed [DW-1:0] e,
                        input int gap, input bit push);
        input_sig = x;
        ready     = 1'b1;
        if (push) sb.push_back('{val: e, due: cyc + TAPS + 1});
        tick();
        ready = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid with %0d want no valid", filtred_sig);
            end else begin
                mon_e = sb.pop_front();
                chk("filtred_sig", filtred_sig, mon_e.val);
                chk("valid_latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running want finished");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; ready = 1'b0; input_sig = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; ovr_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_filtred_sig", filtred_sig, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);

        // Impulse with back-to-back samples accepted in the OUT cycle
        wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 4);
        send(1, 1, 5, 1); send(0, 2, 5, 1); send(0, 3, 5, 1); send(0, 4, 6, 1);

        // Coefficient write while busy must be ignored
        input_sig = 0; ready = 1'b1;
        sb.push_back('{val: 0, due: cyc + TAPS + 1});
        tick(); ready = 1'b0;
        tick();
        chk("busy_in_mac", busy, 1);
        coef_addr = 0; coef_data = 99; coef_we = 1'b1;
        tick(); coef_we = 1'b0;
        repeat (3) tick();
        send(1, 1, 6, 1); send(0, 2, 6, 1); send(0, 3, 6, 1); send(0, 4, 6, 1);

        // Write in the acceptance cycle applies to that sample; signed arithmetic
        coef_addr = 0; coef_data = -7; coef_we = 1'b1;
        input_sig = 2; ready = 1'b1;
        sb.push_back('{val: -14, due: cyc + TAPS + 1});
        tick(); ready = 1'b0; coef_we = 1'b0;
        repeat (4) tick();
        send(0, 4, 5, 1); send(-3, 27, 6, 1);

        // Overrun: dropped sample leaves history untouched, set wins over clear
        input_sig = 1; ready = 1'b1;
        sb.push_back('{val: -5, due: cyc + TAPS + 1});
        tick(); ready = 1'b0;
        tick();
        input_sig = 100; ready = 1'b1;
        tick(); ready = 1'b0;
        chk("overrun_set", overrun, 1);
        repeat (4) tick();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("overrun_clear", overrun, 0);
        input_sig = 0; ready = 1'b1;
        sb.push_back('{val: -7, due: cyc + TAPS + 1});
        tick(); ready = 1'b0;
        tick();
        input_sig = 55; ready = 1'b1; ovr_clr = 1'b1;
        tick(); ready = 1'b0; ovr_clr = 1'b0;
        chk("overrun_set_wins", overrun, 1);
        repeat (4) tick();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("overrun_clear2", overrun, 0);

        // Full-scale inputs and coefficients: wrap or saturate
        do_reset();
        for (int i = 0; i < TAPS; i++) wcoef(2'(i), 18'(FS));
        send(18'(FS), FS1, 5, 1); send(18'(FS), FS2, 5, 1); send(18'(FS), FS3, 5, 1);
        send(18'(FS), FS4, 5, 1); send(18'(FS), FS4, 6, 1);

        // Reset during MAC at k=2 aborts without valid and clears all state
        input_sig = 18'(FS); ready = 1'b1;
        tick(); ready = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midmac_filtred_sig", filtred_sig, 0);
        chk("midmac_valid", valid, 0);
        chk("midmac_busy", busy, 0);
        chk("midmac_overrun", overrun, 0);
        repeat (6) tick();
        wcoef(0, 5); wcoef(1, 6);
        send(1, 5, 5, 1); send(0, 6, 5, 1); send(0, 0, 5, 1); send(0, 0, 6, 1);

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
